gate_out_serializer: RTL and testbench
======================================

# gate_out_serializer

Consumes the parallel result vector that `dot_prod` presents on `outputVec` when `dataReady` rises. Each vector is captured into a two-bank ping-pong buffer, then streamed element by element on a valid/ready interface. The block sits between a gate's dot-product engine and the downstream element-wise stage (activation / cell update), which processes one Qn.m sample per cycle. It decouples the dot-product throughput from downstream back-pressure and flags any result vector that is lost.

## Interface
- `NROW`, 16: number of elements per result vector (hidden size).
- `QN`, 6: integer bits of the fixed-point format.
- `QM`, 11: fractional bits of the fixed-point format.
- `BITWIDTH`, QN+QM+1 (derived): element width, signed two's complement.
- `MEMORY_BITWIDTH`, BITWIDTH*NROW (derived): width of `outputVec`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `dataReady`  in  1  result-valid from `dot_prod`; level or pulse.
- `outputVec`  in  MEMORY_BITWIDTH  result vector; element k occupies bits [k*BITWIDTH +: BITWIDTH].
- `out_data`  out  BITWIDTH  current element, registered.
- `out_valid`  out  1  `out_data` holds a valid element.
- `out_ready`  in  1  downstream accepts the element this cycle.
- `out_last`  out  1  high together with `out_valid` on element NROW-1.
- `busy`  out  1  at least one bank is holding an unsent vector.
- `overrun`  out  1  sticky; a vector arrived while both banks were full.

## Operation
- Capture event: `dataReady` is high and the registered copy `dataReady_q` is low (rising edge). A level held high produces exactly one capture.
- On a capture, `outputVec` is written into the free bank and that bank is marked full. If both banks are free, bank 0 is used first. Banks then alternate strictly.
- Read side:
  - Serializes the oldest full bank, element 0 first, using an index counter 0..NROW-1.
  - The index advances on each handshake (`out_valid && out_ready`).
  - At index NROW-1 the handshake frees the bank, resets the index to 0, and switches to the other bank if it is full.
  - Consecutive vectors stream with no bubble.
- `out_data`, `out_valid` and `out_last` are registered. While `out_valid` is high and `out_ready` is low, all three hold stable.
- No arithmetic is performed. Elements pass through bit-exact with no sign change or rounding.
- Overrun:
  - A capture while both banks are full is discarded and sets `overrun`.
  - The stored data and the read order are unaffected.
  - `overrun` clears only on `reset`.
- Simultaneous capture and final-element handshake while both banks are full: the freed bank counts as free in that cycle. The capture succeeds and `overrun` does not set.
- `busy` = OR of the two bank-full flags.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `overrun`=0. Index=0, both banks empty, `dataReady_q`=0, write pointer=bank 0.
- Latency: `dataReady` rises at edge N → capture at edge N → `busy`=1 after edge N → `out_valid`=1 with element 0 after edge N+1.
- Throughput: with `out_ready` held high, one element per cycle, NROW cycles per vector. The last element of vector A and element 0 of vector B appear on adjacent cycles.
- `out_last` is high only on the cycle carrying element NROW-1 (held through stalls).
- `busy` drops on the edge that completes the final handshake of the last full bank. `out_valid` drops on the same edge.
- Reset asserted mid-stream: all outputs go to their reset values asynchronously and any partial vector is discarded. After `reset` deasserts, the next rising edge of `dataReady` is captured normally. A `dataReady` already high at deassert is treated as a new rising edge, because `dataReady_q` was cleared.

## Test plan
- Single vector (element k = (k+1)<<11, i.e. k+1.0 in Q6.11), `out_ready`=1: 16 elements 18'h00800, 18'h01000 … 18'h08000 on 16 consecutive cycles. `out_last` is high only with 18'h08000. `out_valid` first rises 2 edges after `dataReady` rises.
- Negative and extreme values: elements 18'h20000, 18'h1FFFF, 18'h3FFFF → emerge bit-exact in order.
- Back-pressure: toggle `out_ready` 1/0 each cycle → every element is delivered exactly once, `out_data` stays stable while stalled, and a full vector takes 32 cycles.
- Three vectors, `out_ready`=0 until the third `dataReady` pulse:
  - the first two vectors are buffered and `overrun`=1;
  - after releasing `out_ready`, vectors 1 and 2 stream back-to-back with no bubble (32 consecutive valid cycles);
  - vector 3 is never output.
- Both banks full, and `dataReady` rises on the same edge as the final element's handshake → new vector accepted, `overrun` stays 0, it streams after the current bank.
- `reset` pulse at element 5 of a vector → `out_valid`/`busy` drop immediately. The next vector streams from element 0 and `overrun`=0.

Source files
------------

// File: rtl/gate_out_serializer.sv
// gate_out_serializer: captures dot_prod result vectors into a two-bank
// ping-pong buffer and streams them one Qn.m element per cycle on a
// valid/ready interface. A vector that arrives while both banks are full is
// dropped and flagged on the sticky overrun output.
module gate_out_serializer #(
  parameter int NROW            = 16,
  parameter int QN              = 6,
  parameter int QM              = 11,
  parameter int BITWIDTH        = QN + QM + 1,
  parameter int MEMORY_BITWIDTH = BITWIDTH * NROW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dataReady,
  input  logic [MEMORY_BITWIDTH-1:0] outputVec,
  output logic [BITWIDTH-1:0]        out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun
);

  localparam int             IW       = (NROW > 1) ? $clog2(NROW) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NROW - 1);
  localparam logic           SINGLE   = (NROW == 1);

  // Per-element view of the incoming vector
  logic [NROW-1:0][BITWIDTH-1:0] lanes;

  genvar k;
  generate
    for (k = 0; k < NROW; k++) begin : g_lane
      assign lanes[k] = outputVec[k*BITWIDTH +: BITWIDTH];
    end
  endgenerate

  logic [NROW-1:0][BITWIDTH-1:0] mem [2];
  logic [1:0]    full;
  logic          wr;       // bank the next capture goes into
  logic          rd;       // bank currently being serialized
  logic [IW-1:0] idx;      // index of the element held in out_data
  logic [IW-1:0] idx_inc;
  logic          dr_q;

  logic capture, hs, last_hs, wr_free, accept, nxt_bank, load_next;

  assign capture   = dataReady & ~dr_q;
  assign hs        = out_valid & out_ready;
  assign last_hs   = hs & (idx == LAST_IDX);
  // A bank freed by this cycle's final handshake can be refilled in the same
  // cycle, so a back-to-back arrival with both banks full is not an overrun.
  assign wr_free   = ~full[wr] | (last_hs & (rd == wr));
  assign accept    = capture & wr_free;
  assign nxt_bank  = last_hs ? ~rd : rd;
  assign load_next = hs & (idx != LAST_IDX);
  assign idx_inc   = idx + 1'b1;
  assign busy      = |full;

  // Registered copy of dataReady for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) dr_q <= 1'b0;
    else       dr_q <= dataReady;
  end

  // Bank occupancy, write pointer and sticky overrun; a set on the freed bank wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full    <= 2'b00;
      wr      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (last_hs) full[rd] <= 1'b0;
      if (accept) begin
        full[wr] <= 1'b1;
        wr       <= ~wr;
      end
      if (capture & ~wr_free) overrun <= 1'b1;
    end
  end

  // Bank storage; contents are only meaningful while the bank is full
  always_ff @(posedge clock) begin
    if (accept) mem[wr] <= lanes;
  end

  // Output register: next element of the same bank on a handshake, or element 0
  // of the next full bank when idle or after the final handshake (no bubble)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      idx       <= '0;
      rd        <= 1'b0;
    end else if (load_next) begin
      out_data <= mem[rd][idx_inc];
      idx      <= idx_inc;
      out_last <= (idx_inc == LAST_IDX);
    end else if (~out_valid | last_hs) begin
      rd  <= nxt_bank;
      idx <= '0;
      if (full[nxt_bank]) begin
        out_data  <= mem[nxt_bank][0];
        out_valid <= 1'b1;
        out_last  <= SINGLE;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gate_out_serializer.sv
// Scoreboard bench for gate_out_serializer: stimulus pushes expected elements,
// a negedge monitor pops and compares on every handshake and checks stalls.
module tb_gate_out_serializer;
  localparam int NROW = 16;
  localparam int BW   = 18;
  localparam int MW   = BW * NROW;

  typedef logic [NROW-1:0][BW-1:0] vec_t;
  typedef struct packed {
    logic [BW-1:0] d;
    logic          last;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          dataReady;
  logic [MW-1:0] outputVec;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overrun;

  gate_out_serializer #(.NROW(NROW), .QN(6), .QM(11)) dut (
    .clock(clock), .reset(reset), .dataReady(dataReady), .outputVec(outputVec),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input vec_t v);
    for (int i = 0; i < NROW; i++) q.push_back('{d: v[i], last: (i == NROW - 1)});
  endtask

  // One dataReady pulse; capture happens on the second posedge
  task automatic send(input vec_t v);
    @(posedge clock); #1;
    outputVec = v;
    dataReady = 1'b1;
    @(posedge clock); #1;
    dataReady = 1'b0;
  endtask

  // Called at a negedge: counts consecutive cycles with out_valid high
  task automatic count_run(output int n);
    n = 0;
    while (out_valid && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    @(negedge clock);
    while ((q.size() != 0 || out_valid) && c < budget) begin
      c++;
      @(negedge clock);
    end
    chk(name, (q.size() == 0 && !out_valid), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dataReady = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
  endtask

  // Monitor: compare every accepted element, and check stability across stalls
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_d;
  logic          prev_l;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_last", out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_elem: got %0h expected no element", out_data);
        end else begin
          mon_e = q.pop_front();
          chk("elem_data", out_data, mon_e.d);
          chk("elem_last", out_last, mon_e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  vec_t va, vb, vc, vd;
  int   n, c;
  logic armed;

  initial begin
    reset = 1'b1; dataReady = 1'b0; out_ready = 1'b0; outputVec = '0;
    for (int i = 0; i < NROW; i++) begin
      va[i] = BW'((i + 1) << 11);
      vb[i] = BW'(i * 32'h1111);
      vc[i] = BW'(32'h3FFFF - i * 7);
      vd[i] = BW'(i * 32'h123 + 7);
    end
    vb[0] = 18'h20000; vb[1] = 18'h1FFFF; vb[2] = 18'h3FFFF;

    // Reset state
    @(posedge clock); #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clock); #1 reset = 1'b0;

    // Single vector, latency and throughput
    out_ready = 1'b1;
    push_vec(va);
    @(posedge clock); #1;
    outputVec = va; dataReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t1_busy_after_capture", busy, 1);
    chk("t1_valid_after_capture", out_valid, 0);
    @(posedge clock); #1 dataReady = 1'b0;
    @(negedge clock);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_data", out_data, 18'h00800);
    count_run(n);
    chk("t1_run_len", n, 16);
    chk("t1_busy_idle", busy, 0);
    chk("t1_queue_empty", q.size(), 0);

    // Negative and extreme values
    push_vec(vb);
    send(vb);
    wait_drain("t2_drain", 100);

    // Back-pressure: out_ready alternates, stalled on the first valid cycle
    out_ready = 1'b0;
    push_vec(vc);
    send(vc);
    c = 0;
    @(negedge clock);
    while (!out_valid && c < 20) begin c++; @(negedge clock); end
    chk("t3_valid_seen", out_valid, 1);
    n = 0;
    while (out_valid && n < 100) begin
      n++;
      @(posedge clock); #1 out_ready = ~out_ready;
      @(negedge clock);
    end
    chk("t3_run_len", n, 32);
    out_ready = 1'b1;
    wait_drain("t3_drain", 50);

    // Three vectors with out_ready low: third is dropped, overrun sets
    out_ready = 1'b0;
    push_vec(vd);
    push_vec(vb);
    send(vd);
    send(vb);
    send(vc);
    @(negedge clock);
    chk("t4_overrun", overrun, 1);
    chk("t4_busy", busy, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_head", out_data, vd[0]);
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    count_run(n);
    chk("t4_run_len", n, 32);
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_queue_empty", q.size(), 0);
    do_reset();
    @(negedge clock);
    chk("t4_overrun_cleared", overrun, 0);

    // Capture on the same edge as the final handshake with both banks full
    out_ready = 1'b0;
    push_vec(va);
    push_vec(vb);
    push_vec(vc);
    send(va);
    send(vb);
    outputVec = vc;
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    n = 0;
    armed = 1'b0;
    while (out_valid && n < 200) begin
      n++;
      if (armed && dataReady) dataReady = 1'b0;
      if (out_last && !armed) begin
        dataReady = 1'b1;
        armed = 1'b1;
      end
      @(negedge clock);
    end
    chk("t5_run_len", n, 48);
    chk("t5_overrun", overrun, 0);
    chk("t5_queue_empty", q.size(), 0);

    // Reset mid-vector at element 5
    out_ready = 1'b1;
    push_vec(vd);
    send(vd);
    c = 0;
    @(negedge clock);
    while (!(out_valid && out_data == vd[5]) && c < 50) begin c++; @(negedge clock); end
    chk("t6_reached_elem5", c < 50, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_data", out_data, 0);
    q.delete();
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    push_vec(va);
    send(va);
    wait_drain("t6_drain", 100);
    chk("t6_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
